// File: rtl/armleocpu_decode.sv
// armleocpu_decode: single-slot decode stage between fetch and execute.
//
// Holds one registered instruction slot and tracks whether fetch may run
// freely (RUN), must be held off while a serializing instruction runs
// (SERIAL), or is being drained after a branch until the branch target
// shows up (KILL).
//
// Optional feature: define ARMLEOCPU_DECODE_ILLEGAL_CHECK_EN to register an
// illegal-opcode flag with the slot and to treat illegal instructions as
// serializing. Without it d2e_illegal is tied to 0.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-high reset
//   f2d_valid/type/instr/pc  instruction bus from fetch
//   d2f_ready/cmd/branchtarget  command bus back to fetch (combinational)
//   d2e_valid/type/instr/pc/illegal  registered slot to execute
//   e2d_ready/cmd/branchtarget  slot consume and command from execute
//   debug_state              current FSM state (RUN=0, SERIAL=1, KILL=2)
//
// Handshake: a transfer on f2d happens in a cycle where f2d_valid and
// d2f_ready are both 1; the slot is consumed in a cycle where d2e_valid and
// e2d_ready are both 1. d2f_ready never depends on f2d_valid.

`ifndef F2E_TYPE_WIDTH
`define F2E_TYPE_WIDTH 2
`endif
`ifndef F2E_TYPE_INSTR
`define F2E_TYPE_INSTR 2'd0
`endif
`ifndef F2E_TYPE_INTERRUPT_PENDING
`define F2E_TYPE_INTERRUPT_PENDING 2'd1
`endif
`ifndef ARMLEOCPU_E2F_CMD_WIDTH
`define ARMLEOCPU_E2F_CMD_WIDTH 2
`endif
`ifndef ARMLEOCPU_E2F_CMD_NONE
`define ARMLEOCPU_E2F_CMD_NONE 2'd0
`endif
`ifndef ARMLEOCPU_E2F_CMD_START_BRANCH
`define ARMLEOCPU_E2F_CMD_START_BRANCH 2'd1
`endif
`ifndef ARMLEOCPU_E2F_CMD_FLUSH
`define ARMLEOCPU_E2F_CMD_FLUSH 2'd2
`endif
`ifndef ARMLEOCPU_E2F_CMD_ABORT
`define ARMLEOCPU_E2F_CMD_ABORT 2'd3
`endif

module armleocpu_decode #(
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic                                clk,
    input  logic                                rst,

    input  logic                                f2d_valid,
    input  logic [`F2E_TYPE_WIDTH-1:0]          f2d_type,
    input  logic [31:0]                         f2d_instr,
    input  logic [31:0]                         f2d_pc,

    output logic                                d2f_ready,
    output logic [`ARMLEOCPU_E2F_CMD_WIDTH-1:0] d2f_cmd,
    output logic [31:0]                         d2f_branchtarget,

    output logic                                d2e_valid,
    output logic [`F2E_TYPE_WIDTH-1:0]          d2e_type,
    output logic [31:0]                         d2e_instr,
    output logic [31:0]                         d2e_pc,
    output logic                                d2e_illegal,

    input  logic                                e2d_ready,
    input  logic [`ARMLEOCPU_E2F_CMD_WIDTH-1:0] e2d_cmd,
    input  logic [31:0]                         e2d_branchtarget,

    output logic [1:0]                          debug_state
);

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_SERIAL = 2'd1;
    localparam logic [1:0] ST_KILL   = 2'd2;

    localparam logic [6:0] OP_SYSTEM   = 7'b1110011;
    localparam logic [6:0] OP_MISC_MEM = 7'b0001111;

    logic [1:0]  state_q, state_d;
    logic [31:0] target_q;

    logic slot_free, accept, start_branch, kill_match, f2d_serial;
    logic load, clear;

    assign slot_free    = !d2e_valid || e2d_ready;
    assign accept       = f2d_valid && d2f_ready;
    assign start_branch = (e2d_cmd == `ARMLEOCPU_E2F_CMD_START_BRANCH);
    assign kill_match   = f2d_valid && (f2d_pc == target_q);

`ifdef ARMLEOCPU_DECODE_ILLEGAL_CHECK_EN
    logic f2d_legal;
    logic illegal_q;

    always_comb begin
        f2d_legal = 1'b0;
        if (f2d_instr[1:0] == 2'b11) begin
            case (f2d_instr[6:0])
                7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
                7'b1100011, 7'b0000011, 7'b0100011, 7'b0010011,
                7'b0110011, OP_MISC_MEM, OP_SYSTEM: f2d_legal = 1'b1;
                default: f2d_legal = 1'b0;
            endcase
        end
    end
`endif

    // Instructions that must drain execute before anything younger runs.
    assign f2d_serial = (f2d_type == `F2E_TYPE_INTERRUPT_PENDING)
                     || (f2d_instr[6:0] == OP_SYSTEM)
                     || ((f2d_instr[6:0] == OP_MISC_MEM) && (f2d_instr[14:12] == 3'b001))
`ifdef ARMLEOCPU_DECODE_ILLEGAL_CHECK_EN
                     || !f2d_legal
`endif
                     ;

    // In KILL only the instruction at the branch target is taken; a branch
    // in the same cycle always wins over any incoming instruction.
    assign load  = !start_branch
                && (((state_q == ST_RUN) && accept) || ((state_q == ST_KILL) && kill_match));
    assign clear = start_branch || (!load && slot_free);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_RUN;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (start_branch) begin
            state_d = ST_KILL;
        end else begin
            case (state_q)
                ST_RUN:    if (accept && f2d_serial) state_d = ST_SERIAL;
                ST_KILL:   if (kill_match) state_d = f2d_serial ? ST_SERIAL : ST_RUN;
                ST_SERIAL: state_d = ST_SERIAL;
                default:   state_d = ST_RUN;
            endcase
        end
    end

    // Output logic toward fetch
    always_comb begin
        d2f_ready        = 1'b0;
        d2f_cmd          = `ARMLEOCPU_E2F_CMD_NONE;
        d2f_branchtarget = e2d_branchtarget;
        if (!rst) begin
            d2f_ready = (state_q == ST_RUN) ? slot_free : 1'b1;
            if (start_branch || (e2d_cmd == `ARMLEOCPU_E2F_CMD_FLUSH))
                d2f_cmd = e2d_cmd;
            else if (state_q == ST_SERIAL)
                d2f_cmd = `ARMLEOCPU_E2F_CMD_ABORT;
        end
    end

    // Instruction slot and captured branch target
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d2e_valid <= 1'b0;
            d2e_instr <= NOP_INSTR;
            d2e_pc    <= 32'h0;
            d2e_type  <= `F2E_TYPE_INSTR;
            target_q  <= 32'h0;
        end else begin
            if (load) begin
                d2e_valid <= 1'b1;
                d2e_instr <= f2d_instr;
                d2e_pc    <= f2d_pc;
                d2e_type  <= f2d_type;
            end else if (clear) begin
                d2e_valid <= 1'b0;
                d2e_instr <= NOP_INSTR;
            end
            if (start_branch) target_q <= e2d_branchtarget;
        end
    end

`ifdef ARMLEOCPU_DECODE_ILLEGAL_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)        illegal_q <= 1'b0;
        else if (load)  illegal_q <= !f2d_legal;
        else if (clear) illegal_q <= 1'b0;
    end
    assign d2e_illegal = illegal_q;
`else
    assign d2e_illegal = 1'b0;
`endif

    assign debug_state = state_q;

endmodule

// File: doc/armleocpu_decode.md
ARMLEOCPU_DECODE -- requirements
Module: armleocpu_decode

Interface
REQ-001 SHALL have parameter NOP_INSTR, default 32'h00000013, the value d2e_instr holds while d2e_valid=0.
REQ-002 SHALL have ports: clk  in  1  clock, rising edge; rst  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have ports: f2d_valid in 1; f2d_type in `F2E_TYPE_WIDTH; f2d_instr in 32; f2d_pc in 32; together the instruction bus from fetch.
REQ-004 SHALL have ports: d2f_ready out 1; d2f_cmd out `ARMLEOCPU_E2F_CMD_WIDTH; d2f_branchtarget out 32; together the command bus to fetch (fetch's e2f_ready/e2f_cmd/e2f_branchtarget inputs).
REQ-005 SHALL have ports: d2e_valid out 1; d2e_type out `F2E_TYPE_WIDTH; d2e_instr out 32; d2e_pc out 32; d2e_illegal out 1; together the registered instruction slot to execute.
REQ-006 SHALL have ports: e2d_ready in 1, execute consumes the slot; e2d_cmd in `ARMLEOCPU_E2F_CMD_WIDTH; e2d_branchtarget in 32.

Function
REQ-007 SHALL hold one registered instruction slot and a state register with states RUN, SERIAL and KILL.
REQ-008 Slot free SHALL be defined as !d2e_valid || e2d_ready.
REQ-009 In RUN, d2f_ready SHALL equal slot free; in SERIAL and KILL, d2f_ready SHALL be 1, and accepted instructions are discarded unless REQ-013 applies.
REQ-010 In RUN, an accepted f2d (f2d_valid && d2f_ready) SHALL load the slot next cycle (d2e_valid=1, fields copied, latency 1); if slot free and nothing is accepted, d2e_valid SHALL go to 0.
REQ-011 Serializing means: f2d_type==`F2E_TYPE_INTERRUPT_PENDING, opcode 7'b1110011 (SYSTEM/CSR), or opcode 7'b0001111 with funct3 3'b001 (FENCE.I); an accepted serializing instruction SHALL move RUN->SERIAL.
REQ-012 An e2d_cmd==START_BRANCH in any state SHALL clear d2e_valid, discard any same-cycle f2d, capture e2d_branchtarget, and move to KILL.
REQ-013 In KILL, the first f2d with f2d_valid and f2d_pc==captured target SHALL load the slot and move to RUN, or to SERIAL if it is serializing; all other f2d SHALL be discarded.
REQ-014 d2f_cmd/d2f_branchtarget SHALL be combinational with priority:
  - e2d_cmd START_BRANCH or FLUSH: forwarded, with d2f_branchtarget=e2d_branchtarget;
  - else state SERIAL: ABORT;
  - else NONE.
REQ-015 e2d_cmd FLUSH SHALL NOT change state or slot.
REQ-016 SERIAL SHALL exit only through REQ-012; execute always issues START_BRANCH (pc+4 or trap vector) after a serializing instruction.
REQ-017 While d2e_valid=0, d2e_instr SHALL be NOP_INSTR and d2e_illegal 0; d2e_pc and d2e_type hold their last values.

Reset
REQ-018 While rst=1: d2e_valid=0, d2e_instr=NOP_INSTR, d2e_pc=0, d2e_type=`F2E_TYPE_INSTR, d2e_illegal=0, state=RUN, captured target=0.
REQ-019 While rst=1, d2f_cmd SHALL be NONE and d2f_ready 0.
REQ-020 Reset asserted mid-SERIAL or mid-KILL SHALL return to RUN immediately, with no residual ABORT.

Configuration
REQ-021 With ARMLEOCPU_DECODE_ILLEGAL_CHECK_EN defined:
  - d2e_illegal SHALL be registered with the slot, set when instr[1:0]!=2'b11 or opcode is not an RV32I/Zicsr/Zifencei opcode;
  - an illegal instruction SHALL be serializing.
REQ-022 Without ARMLEOCPU_DECODE_ILLEGAL_CHECK_EN, d2e_illegal SHALL be constant 0 and legality SHALL NOT affect serialization.

Verification
REQ-023 Reset release, f2d ADDI pc=0x1000, e2d_ready=1 -> next cycle d2e_valid=1, d2e_pc=0x1000, d2f_cmd NONE.
REQ-024 Slot full, e2d_ready=0, f2d_valid=1 -> d2f_ready=0; slot unchanged until e2d_ready=1.
REQ-025 Accept CSRRW pc=0x2000 -> ABORT every cycle; f2d pc=0x2004 discarded; e2d START_BRANCH 0x2004 forwarded same cycle; next f2d pc=0x2004 loaded, state RUN.
REQ-026 Slot holds pc=0x3008; e2d START_BRANCH target 0x4000 with same-cycle f2d pc=0x300C -> d2e_valid=0; pc=0x300C and 0x3010 discarded; pc=0x4000 loaded.
REQ-027 Accept FENCE.I, e2d FLUSH then START_BRANCH 0x5004 -> d2f_cmd FLUSH, then START_BRANCH, ABORT in other SERIAL cycles.
REQ-028 With macro, instr 32'h00000000 -> d2e_illegal=1 and SERIAL; without macro -> d2e_illegal=0 and RUN.
